ram_loader: RTL and testbench

Boot-time image loader sitting directly upstream of the 4096×8 program RAM. It accepts a framed byte stream over a valid/ready handshake, writes the payload into RAM through the RAM's write port, and holds the CPU off the RAM port until a GO command arrives. While `cpu_hold` is high, the loader owns `addr`/`data_in`/`we` of the RAM. The top level muxes the port to the CPU once `cpu_hold` falls.

---
 rtl/ram_loader.sv | 208 ++++++++++++++++++++
 tb/tb_ram_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: boot-time image loader in front of the 4096x8 program RAM.
// Parses framed load commands from a valid/ready byte stream, writes the
// payload into RAM and holds the CPU off the RAM port until a GO byte.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   rx_data   incoming stream byte
//   rx_valid  rx_data is valid
//   rx_ready  loader accepts a byte this cycle (low only after GO)
//   mem_addr  RAM write address
//   mem_data  RAM write data
//   mem_we    RAM write enable, one cycle per accepted payload byte
//   cpu_hold  loader owns the RAM port; falls after GO
//   done      one-cycle pulse for a frame with a good checksum
//   error     sticky error flag, cleared only by reset
module ram_loader #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;   // payload length minus one
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          rx_ready_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_data_d;
  logic          mem_we_d;
  logic          cpu_hold_d;
  logic          done_d;
  logic          error_d;

  logic          xfer_c;
  logic [DW-1:0] sum_add_c;

  assign xfer_c    = rx_valid && rx_ready;
  assign sum_add_c = sum_q + rx_data;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      rx_ready <= 1'b1;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      rx_ready <= rx_ready_d;
      mem_addr <= mem_addr_d;
      mem_data <= mem_data_d;
      mem_we   <= mem_we_d;
      cpu_hold <= cpu_hold_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    mem_addr_d = mem_addr;
    mem_data_d = mem_data;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    error_d    = error;

    case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          if (rx_data == 8'hA5) begin
            state_d = S_ADDR_HI;
            sum_d   = '0;
          end else if (rx_data == 8'h5A) begin
            state_d = S_RUN;
          end
        end
      end
      S_ADDR_HI: begin
        if (xfer_c) begin
          if (rx_data[7:4] != 4'h0) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            base_d[11:8] = rx_data[3:0];
            sum_d        = sum_add_c;
            state_d      = S_ADDR_LO;
          end
        end
      end
      S_ADDR_LO: begin
        if (xfer_c) begin
          base_d[7:0] = rx_data;
          sum_d       = sum_add_c;
          state_d     = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          if (rx_data[7:4] != 4'h0) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d[11:8] = rx_data[3:0];
            sum_d       = sum_add_c;
            state_d     = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_d[7:0] = rx_data;
          sum_d      = sum_add_c;
          idx_d      = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          mem_we_d   = 1'b1;
          mem_addr_d = base_q + idx_q;   // wraps naturally at 12 bits
          mem_data_d = rx_data;
          sum_d      = sum_add_c;
          idx_d      = idx_q + AW'(1);
          if (idx_q == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer_c) begin
          if (sum_add_c == 8'h00) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
      end
    endcase

    // Inter-byte timeout inside a frame; a transfer restarts the count
    if (state_q != S_IDLE && state_q != S_RUN && !xfer_c) begin
      if (tmo_q == TMO_LAST) begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // RUN is terminal, so hold and ready both follow it
    rx_ready_d = (state_d != S_RUN);
    cpu_hold_d = (state_d != S_RUN);
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: self-checking bench for ram_loader. Frames are built from
// random or directed payloads; the expected RAM writes, done pulses and
// sticky error are derived from the frame format and compared against a
// negedge monitor of the RAM port.
module tb_ram_loader;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  cyc       = 0;
  int  done_cnt  = 0;
  int  exp_done  = 0;
  bit  exp_err   = 1'b0;
  int  n_vec     = 0;
  int  n_err     = 0;

  always #5 clk = ~clk;

  ram_loader #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // RAM port monitor
  always @(negedge clk) begin
    if (mem_we) obs_q.push_back('{int'(mem_addr), int'(mem_data), cyc});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic gap(input int maxgap);
    if (maxgap > 0) idle($urandom_range(0, maxgap));
  endtask

  task automatic send_byte(input logic [7:0] b);
    check("rx_ready", rx_ready, 1'b1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic verify_writes(input bit consec);
    check("wr_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("wr_addr", obs_q[i].addr, exp_q[i].addr);
      check("wr_data", obs_q[i].data, exp_q[i].data);
      if (consec && i > 0) check("wr_consec", obs_q[i].cyc - obs_q[i-1].cyc, 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Asserts reset, checks reset values immediately, settles the model
  task automatic do_reset();
    rx_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_mem_we",   mem_we,   1'b0);
    check("rst_mem_addr", mem_addr, 12'h000);
    check("rst_mem_data", mem_data, 8'h00);
    check("rst_done",     done,     1'b0);
    check("rst_error",    error,    1'b0);
    verify_writes(1'b1);
    done_cnt = 0;
    exp_done = 0;
    exp_err  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // hdr_err: 0 none, 1 bad ADDR_HI nibble, 2 bad LEN_HI nibble
  task automatic send_frame(input int base, input logic [7:0] pl[$], input bit bad,
                            input int hdr_err, input int maxgap);
    logic [7:0] hb[4];
    logic [7:0] s;
    logic [7:0] cs;
    int         n;
    n     = pl.size();
    hb[0] = 8'((base >> 8) & 15);
    hb[1] = 8'(base & 255);
    hb[2] = 8'(((n - 1) >> 8) & 15);
    hb[3] = 8'((n - 1) & 255);
    if (hdr_err == 1) hb[0] = hb[0] | 8'($urandom_range(1, 15) << 4);
    if (hdr_err == 2) hb[2] = hb[2] | 8'($urandom_range(1, 15) << 4);
    gap(maxgap);
    send_byte(8'hA5);
    s = 8'h00;
    for (int i = 0; i < 4; i++) begin
      gap(maxgap);
      send_byte(hb[i]);
      s = s + hb[i];
      if ((i == 0 && hdr_err == 1) || (i == 2 && hdr_err == 2)) begin
        exp_err = 1'b1;
        check("hdr_error", error, 1'b1);
        check("hdr_done", done, 1'b0);
        verify_writes(1'b0);
        return;
      end
    end
    for (int i = 0; i < n; i++) begin
      gap(maxgap);
      send_byte(pl[i]);
      s = s + pl[i];
      exp_q.push_back('{(base + i) % 4096, int'(pl[i]), 0});
    end
    cs = 8'((256 - int'(s)) % 256);
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    gap(maxgap);
    send_byte(cs);
    check("done_pulse", done, !bad);
    if (bad) exp_err = 1'b1;
    else     exp_done++;
    check("error_flag", error, exp_err);
    verify_writes(maxgap == 0);
    idle(1);
    check("done_width", done, 1'b0);
    check("done_count", done_cnt, exp_done);
  endtask

  task automatic go_test();
    check("pre_go_hold", cpu_hold, 1'b1);
    send_byte(8'h5A);
    check("go_hold", cpu_hold, 1'b0);
    check("go_ready", rx_ready, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("run_ready", rx_ready, 1'b0);
    check("run_hold", cpu_hold, 1'b0);
    verify_writes(1'b0);
  endtask

  initial begin
    logic [7:0] pl[$];
    reset_n  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();

    // Load then GO
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(12'h010, pl, 1'b0, 0, 0);
    go_test();
    do_reset();

    // Address wrap from 0xFFF to 0x000
    pl = '{8'hAA, 8'hBB};
    send_frame(12'hFFF, pl, 1'b0, 0, 0);

    // Bad checksum, then a good frame still loads
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(12'h010, pl, 1'b1, 0, 0);
    send_frame(12'h200, pl, 1'b0, 0, 2);
    do_reset();

    // Noise in IDLE is ignored, then a header error
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5B);
    check("noise_error", error, 1'b0);
    check("noise_hold", cpu_hold, 1'b1);
    verify_writes(1'b0);
    send_byte(8'hA5);
    send_byte(8'h10);
    check("hdr10_error", error, 1'b1);
    verify_writes(1'b0);
    exp_err = 1'b1;
    pl = '{8'h5C};
    send_frame(12'h7F0, pl, 1'b0, 2, 0);
    send_frame(12'h7F0, pl, 1'b0, 0, 0);
    do_reset();

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(TMO - 1);
    check("tmo_early", error, 1'b0);
    idle(1);
    check("tmo_error", error, 1'b1);
    verify_writes(1'b0);
    go_test();
    do_reset();

    // Reset in the middle of a payload
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hC1);
    exp_q.push_back('{12'h123, 8'hC1, 0});
    send_byte(8'hC2);
    exp_q.push_back('{12'h124, 8'hC2, 0});
    check("mid_we", mem_we, 1'b1);
    do_reset();
    pl = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    send_frame(12'h123, pl, 1'b0, 0, 0);
    do_reset();

    // Randomized frames with noise, stalls and errors
    for (int it = 0; it < 25; it++) begin
      int nn;
      int base;
      int len;
      int herr;
      bit bad;
      int mg;
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5 || nb == 8'h5A) nb = 8'h00;
        send_byte(nb);
      end
      check("noise_err", error, exp_err);
      base = ($urandom_range(0, 3) == 0) ? 4096 - $urandom_range(1, 10)
                                         : $urandom_range(0, 4095);
      len  = $urandom_range(1, 24);
      herr = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      bad  = ($urandom_range(0, 4) == 0);
      mg   = ($urandom_range(0, 1) == 0) ? 0 : 3;
      pl.delete();
      for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
      send_frame(base, pl, bad, herr, mg);
    end
    go_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
